ghost_sprite_rom: RTL
=====================

# ghost_sprite_rom

Animated ghost sprite source for the Pac-Man video pipeline. It replaces the single fixed ghost bitmap with a parametrised, registered sprite store that holds multiple skirt-animation frames, direction-dependent eyes and the frightened face. It also runs the animation and frightened-blink timers. The ghost drawing logic issues one pixel lookup per cycle and receives classified pixel bits two cycles later, which the colour mapper converts to RGB.

## Interface
Parameters:
- ADDR_WIDTH, 5, log2 of sprite edge length.
- SPRITE_DIM, 32, sprite edge in pixels; must equal 2**ADDR_WIDTH.
- NUM_FRAMES, 2, body animation frames; must be ≥1.
- FRAME_DIV, 8, frame_tick pulses per animation step; must be ≥1.
- BLINK_DIV, 16, frame_tick pulses per blink-phase toggle; must be ≥1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame (vsync).
- mode  in  2  ghost_mode_t: NORMAL, FRIGHT, FRIGHT_BLINK, EYES.
- dir  in  2  ghost_dir_t: RIGHT, LEFT, UP, DOWN.
- rd_en  in  1  pixel lookup request.
- row  in  ADDR_WIDTH  sprite row; 0 is the top row.
- col  in  ADDR_WIDTH  sprite column; 0 is the leftmost pixel (row word MSB).
- pix_valid  out  1  result valid.
- pix_body  out  1  body pixel.
- pix_eye  out  1  eye white, or frightened-face pixel.
- pix_pupil  out  1  pupil pixel.
- pix_flash  out  1  draw the frightened body in the flash colour.
- anim_frame  out  $clog2(NUM_FRAMES), minimum 1  current animation frame.

## Operation
- Contents:
  - Body store: NUM_FRAMES × SPRITE_DIM words.
  - Eye-white store: 4 directions × SPRITE_DIM words.
  - Pupil store: 4 directions × SPRITE_DIM words.
  - Fright-face store: SPRITE_DIM words.
  - Frame 0 body row 5 is 32'h001FFC00. Frames differ only in skirt rows 24–26.
- Animation counter:
  - tick_cnt counts frame_tick pulses from 0 to FRAME_DIV-1.
  - A frame_tick at FRAME_DIV-1 wraps tick_cnt to 0 and advances anim_frame, which wraps from NUM_FRAMES-1 to 0.
  - Animation runs in every mode.
- Blink counter:
  - While mode==FRIGHT_BLINK, blink_cnt counts frame_tick pulses from 0 to BLINK_DIV-1. On wrap, blink_phase toggles.
  - In any other mode, blink_cnt and blink_phase are held at 0 in the cycle after the mode change.
- Per-mode output rules (masks taken at the sampled column):
  - NORMAL: body = body[frame]; eye = eyewhite[dir]; pupil = pupil[dir].
  - FRIGHT: body = body[frame]; eye = fright-face; pupil = 0; flash = 0.
  - FRIGHT_BLINK: as FRIGHT, with flash = blink_phase.
  - EYES: body = 0; eye and pupil as in NORMAL.
- Sampling: mode, dir, anim_frame, blink_phase, row and col are sampled on the rd_en cycle and carried with the request. A later change to any of them does not affect an in-flight lookup.
- When rd_en=0, the pipeline advances a bubble and pix_valid goes 0 in due course. The pixel outputs keep their last values.

## Timing
- Latency is 2 cycles, fully pipelined. rd_en in cycle N produces pix_valid=1 with data in cycle N+2. The block sustains one lookup per cycle with no stalls and no back-pressure.
- Stage 1 registers the selected row words and the sampled controls. Stage 2 registers the column-selected bits and the mode gating.
- Counters update on the clock edge that samples frame_tick. A lookup issued in that same cycle uses the pre-update anim_frame.
- Reset behaviour:
  - All outputs, counters and pipeline valids go to 0 on the first edge with Reset high.
  - Requests in flight are dropped. Reset has priority over frame_tick and rd_en.
  - pix_valid stays 0 until 2 cycles after the first rd_en following reset release.

## Structure
- Package ghost_sprite_pkg holds:
  - the ghost_mode_t and ghost_dir_t enums;
  - the bitmap constants, as packed arrays indexed [frame/dir][row].
- One sub-module, ghost_anim_timer, owns tick_cnt, anim_frame, blink_cnt and blink_phase. The top level holds the stores and the two pipeline stages.

## Test plan
- Reset, then NORMAL, frame 0, rd_en with row=5 and col=11, then col=10 → at N+2: pix_valid=1, pix_body=1, then pix_body=0.
- 8 frame_tick pulses with FRAME_DIV=8 → anim_frame goes 0→1 on the 8th pulse. 8 more pulses → anim_frame wraps to 0. Body row 25 matches the frame 1 word in between.
- FRIGHT_BLINK with BLINK_DIV=16, 16 pulses → pix_flash toggles 0→1. Switching to FRIGHT → blink_phase=0 on the next cycle and pix_flash=0 on the next lookup.
- EYES, dir=LEFT, rd_en on the left-pupil pixel → pix_body=0, pix_pupil=1. Same pixel with dir=RIGHT → pix_pupil=0.
- Continuous rd_en over 32 columns while frame_tick crosses a frame boundary mid-burst → pix_valid high on 32 consecutive cycles. Each pixel reflects the frame sampled at its own request.
- Reset asserted with 2 requests in flight → pix_valid=0 on the following cycles, and anim_frame=0.

Source files
------------

// File: rtl/ghost_sprite_pkg.sv
// Shared types and sprite bitmaps for the animated ghost sprite store.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Row words are GS_DIM bits wide with column 0 in the MSB; arrays index [frame/dir][row].
package ghost_sprite_pkg;

   typedef enum logic [1:0] {
      MODE_NORMAL       = 2'd0,
      MODE_FRIGHT       = 2'd1,
      MODE_FRIGHT_BLINK = 2'd2,
      MODE_EYES         = 2'd3
   } ghost_mode_t;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } ghost_dir_t;

   localparam int GS_DIM    = 32;
   localparam int GS_FRAMES = 2;

   typedef logic [0:GS_DIM-1][GS_DIM-1:0] sprite_t;

   // Body outline; frames differ only in the skirt rows 24..26.
   function automatic sprite_t body_frame(input int frame);
      sprite_t s;
      s = '0;
      s[4] = 32'h000FF000;
      s[5] = 32'h001FFC00;
      s[6] = 32'h007FFE00;
      s[7] = 32'h00FFFF00;
      for (int y = 8; y < 25; y++) s[y] = 32'h01FFFF80;
      if (frame == 0) begin
         s[25] = 32'h01CE7380;
         s[26] = 32'h01842100;
      end else begin
         s[25] = 32'h00E73980;
         s[26] = 32'h00421080;
      end
      return s;
   endfunction

   // Two centred eye whites, cols 8-13 and 18-23, rows 8-13.
   function automatic sprite_t eye_base();
      sprite_t s;
      s = '0;
      s[8] = 32'h00781E00;
      for (int y = 9; y < 13; y++) s[y] = 32'h00FC3F00;
      s[13] = 32'h00781E00;
      return s;
   endfunction

   // Centred 2x2 pupils at rows 10-11, cols 10-11 and 20-21.
   function automatic sprite_t pupil_base();
      sprite_t s;
      s = '0;
      s[10] = 32'h00300C00;
      s[11] = 32'h00300C00;
      return s;
   endfunction

   // Frightened face: small square eyes and a wavy mouth.
   function automatic sprite_t fright_face();
      sprite_t s;
      s = '0;
      s[10] = 32'h00300C00;
      s[11] = 32'h00300C00;
      s[17] = 32'h00555500;
      s[18] = 32'h00AAAA00;
      return s;
   endfunction

   // Displace a bitmap n pixels towards the look direction. Left is towards the MSB.
   function automatic sprite_t look(input sprite_t s, input ghost_dir_t d, input int n);
      sprite_t r;
      r = '0;
      for (int y = 0; y < GS_DIM; y++) begin
         case (d)
            DIR_RIGHT: r[y] = s[y] >> n;
            DIR_LEFT:  r[y] = s[y] << n;
            DIR_UP:    if (y + n < GS_DIM) r[y] = s[y + n];
            default:   if (y >= n) r[y] = s[y - n];
         endcase
      end
      return r;
   endfunction

   localparam logic [0:GS_FRAMES-1][0:GS_DIM-1][GS_DIM-1:0] GHOST_BODY =
      {body_frame(0), body_frame(1)};

   localparam logic [0:3][0:GS_DIM-1][GS_DIM-1:0] GHOST_EYE =
      {look(eye_base(), DIR_RIGHT, 1), look(eye_base(), DIR_LEFT, 1),
       look(eye_base(), DIR_UP, 1),    look(eye_base(), DIR_DOWN, 1)};

   localparam logic [0:3][0:GS_DIM-1][GS_DIM-1:0] GHOST_PUPIL =
      {look(pupil_base(), DIR_RIGHT, 2), look(pupil_base(), DIR_LEFT, 2),
       look(pupil_base(), DIR_UP, 2),    look(pupil_base(), DIR_DOWN, 2)};

   localparam logic [0:GS_DIM-1][GS_DIM-1:0] GHOST_FACE = fright_face();

endpackage

// File: rtl/ghost_anim_timer.sv
// Skirt-animation frame counter and frightened-blink phase, both paced by frame_tick.
// Latency: counters update on the edge that samples frame_tick.
// Backpressure: none; every tick is counted.
// Ports: clk_i/reset_i (sync, active-high), frame_tick_i, blink_en_i (mode is FRIGHT_BLINK),
//        anim_frame_o (current body frame), blink_phase_o (flash colour select).
module ghost_anim_timer #(
   parameter int NUM_FRAMES = 2,
   parameter int FRAME_DIV  = 8,
   parameter int BLINK_DIV  = 16,
   parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               frame_tick_i,
   input  logic               blink_en_i,
   output logic [FRAME_W-1:0] anim_frame_o,
   output logic               blink_phase_o
);
   localparam int TICK_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [TICK_W-1:0]  tick_cnt_q,    tick_cnt_d;
   logic [FRAME_W-1:0] anim_frame_q,  anim_frame_d;
   logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
   logic               blink_phase_q, blink_phase_d;

   always_comb begin
      tick_cnt_d    = tick_cnt_q;
      anim_frame_d  = anim_frame_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;

      if (frame_tick_i) begin
         if (tick_cnt_q == TICK_W'(FRAME_DIV - 1)) begin
            tick_cnt_d   = '0;
            anim_frame_d = (anim_frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : anim_frame_q + 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
      end

      // Leaving FRIGHT_BLINK restarts the blink so the next blink episode starts unflashed.
      if (!blink_en_i) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (frame_tick_i) begin
         if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tick_cnt_q    <= '0;
         anim_frame_q  <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         anim_frame_q  <= anim_frame_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign anim_frame_o  = anim_frame_q;
   assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/ghost_sprite_rom.sv
// Animated ghost sprite store: classifies one sprite pixel per lookup (body/eye/pupil/flash).
// Latency: 2 cycles from rd_en to pix_valid, fully pipelined, one lookup per cycle.
// Backpressure: none; results are never stalled, bubbles drop pix_valid while pixel bits hold.
// Ports: Clk, Reset (sync, active-high), frame_tick, mode, dir, rd_en, row, col in;
//        pix_valid, pix_body, pix_eye, pix_pupil, pix_flash, anim_frame out.
module ghost_sprite_rom
   import ghost_sprite_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int SPRITE_DIM = 32,
   parameter int NUM_FRAMES = 2,
   parameter int FRAME_DIV  = 8,
   parameter int BLINK_DIV  = 16,
   localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_tick,
   input  logic [1:0]            mode,
   input  logic [1:0]            dir,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] row,
   input  logic [ADDR_WIDTH-1:0] col,
   output logic                  pix_valid,
   output logic                  pix_body,
   output logic                  pix_eye,
   output logic                  pix_pupil,
   output logic                  pix_flash,
   output logic [FRAME_W-1:0]    anim_frame
);
   ghost_mode_t mode_in;
   ghost_dir_t  dir_in;
   logic        blink_phase;

   assign mode_in = ghost_mode_t'(mode);
   assign dir_in  = ghost_dir_t'(dir);

   ghost_anim_timer #(
      .NUM_FRAMES (NUM_FRAMES),
      .FRAME_DIV  (FRAME_DIV),
      .BLINK_DIV  (BLINK_DIV),
      .FRAME_W    (FRAME_W)
   ) u_timer (
      .clk_i         (Clk),
      .reset_i       (Reset),
      .frame_tick_i  (frame_tick),
      .blink_en_i    (mode_in == MODE_FRIGHT_BLINK),
      .anim_frame_o  (anim_frame),
      .blink_phase_o (blink_phase)
   );

   // Stage 1: row words selected from the stores plus the controls sampled with the request.
   logic                  s1_vld_q;
   logic [SPRITE_DIM-1:0] s1_body_q,  s1_body_d;
   logic [SPRITE_DIM-1:0] s1_eye_q,   s1_eye_d;
   logic [SPRITE_DIM-1:0] s1_pupil_q, s1_pupil_d;
   logic [ADDR_WIDTH-1:0] s1_col_q,   s1_col_d;
   ghost_mode_t           s1_mode_q,  s1_mode_d;
   logic                  s1_blink_q, s1_blink_d;

   always_comb begin
      // The stored art has two skirt frames; extra frames alternate between them.
      s1_body_d  = GHOST_BODY[anim_frame[0]][row];
      // Frightened ghosts draw the face through the eye channel instead of the eye whites.
      s1_eye_d   = (mode_in == MODE_FRIGHT || mode_in == MODE_FRIGHT_BLINK) ?
                   GHOST_FACE[row] : GHOST_EYE[dir_in][row];
      s1_pupil_d = GHOST_PUPIL[dir_in][row];
      s1_col_d   = col;
      s1_mode_d  = mode_in;
      s1_blink_d = blink_phase;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_vld_q   <= 1'b0;
         s1_body_q  <= '0;
         s1_eye_q   <= '0;
         s1_pupil_q <= '0;
         s1_col_q   <= '0;
         s1_mode_q  <= MODE_NORMAL;
         s1_blink_q <= 1'b0;
      end else begin
         s1_vld_q <= rd_en;
         if (rd_en) begin
            s1_body_q  <= s1_body_d;
            s1_eye_q   <= s1_eye_d;
            s1_pupil_q <= s1_pupil_d;
            s1_col_q   <= s1_col_d;
            s1_mode_q  <= s1_mode_d;
            s1_blink_q <= s1_blink_d;
         end
      end
   end

   // Stage 2: column bit select and per-mode gating.
   logic [ADDR_WIDTH-1:0] bit_sel;
   logic                  pix_body_d, pix_eye_d, pix_pupil_d, pix_flash_d;

   always_comb begin
      bit_sel     = ~s1_col_q;   // column 0 is the word MSB
      pix_body_d  = (s1_mode_q != MODE_EYES) && s1_body_q[bit_sel];
      pix_eye_d   = s1_eye_q[bit_sel];
      pix_pupil_d = (s1_mode_q == MODE_NORMAL || s1_mode_q == MODE_EYES) && s1_pupil_q[bit_sel];
      pix_flash_d = (s1_mode_q == MODE_FRIGHT_BLINK) && s1_blink_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pix_valid <= 1'b0;
         pix_body  <= 1'b0;
         pix_eye   <= 1'b0;
         pix_pupil <= 1'b0;
         pix_flash <= 1'b0;
      end else begin
         pix_valid <= s1_vld_q;
         if (s1_vld_q) begin
            pix_body  <= pix_body_d;
            pix_eye   <= pix_eye_d;
            pix_pupil <= pix_pupil_d;
            pix_flash <= pix_flash_d;
         end
      end
   end

endmodule
